// File: rtl/tick_sequencer_pkg.sv
// Shared definitions for the tick sequencer: FSM state encoding and the
// reset-time divider fallback used when the top is not overridden.
package tick_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_DIV_FALLBACK = 100;

endpackage

// File: rtl/tick_sequencer_if.sv
// Control/status bundle of the tick sequencer.
//   master : controller side (drives config, start, stop; observes strobes)
//   slave  : sequencer side
// Signals: cfg_valid/cfg_ready/cfg_div/cfg_burst config handshake,
//          start/stop run control, tick/busy/done/tick_count status.
interface tick_sequencer_if #(
   parameter int CNT_WIDTH   = 16,
   parameter int BURST_WIDTH = 16
);
   logic                   cfg_valid;
   logic                   cfg_ready;
   logic [CNT_WIDTH-1:0]   cfg_div;
   logic [BURST_WIDTH-1:0] cfg_burst;
   logic                   start;
   logic                   stop;
   logic                   tick;
   logic                   busy;
   logic                   done;
   logic [BURST_WIDTH-1:0] tick_count;

   modport master (
      output cfg_valid, cfg_div, cfg_burst, start, stop,
      input  cfg_ready, tick, busy, done, tick_count
   );

   modport slave (
      input  cfg_valid, cfg_div, cfg_burst, start, stop,
      output cfg_ready, tick, busy, done, tick_count
   );
endinterface

// File: rtl/tick_sequencer_period_counter.sv
// Period counter: counts 0..dm1 while enabled and wraps.
// Ports: clk, rst_n  - clock / async active-low reset
//        clear_i     - force count to 0 (takes priority over en_i)
//        en_i        - advance the count
//        dm1_i       - terminal count (effective divider minus one)
//        wrap_o      - combinational: this edge is a period boundary
module tick_period_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear_i,
   input  logic                 en_i,
   input  logic [CNT_WIDTH-1:0] dm1_i,
   output logic                 wrap_o
);
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   assign wrap_o = en_i && (cnt_q == dm1_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)      cnt_d = '0;
      else if (wrap_o)  cnt_d = '0;
      else if (en_i)    cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/tick_sequencer.sv
// Tick sequencer: programmable-period single-cycle clock-enable strobe with
// continuous or fixed-length burst runs and start/stop control.
// Ports: clk, rst_n - clock / async active-low reset
//        bus        - tick_sequencer_if.slave (config handshake, start/stop,
//                     tick/busy/done/tick_count)
// Config arriving during a run is held in a shadow register and applied on a
// period boundary (or at a stop), so a period is never cut short or stretched.
module tick_sequencer
   import tick_sequencer_pkg::*;
#(
   parameter int CNT_WIDTH   = 16,
   parameter int BURST_WIDTH = 16,
   parameter int DEFAULT_DIV = DEFAULT_DIV_FALLBACK
) (
   input logic               clk,
   input logic               rst_n,
   tick_sequencer_if.slave   bus
);
   state_e                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   div_q, div_d, sh_div_q, sh_div_d;
   logic [BURST_WIDTH-1:0] burst_q, burst_d, sh_burst_q, sh_burst_d;
   logic [BURST_WIDTH-1:0] tc_q, tc_d, tc_inc;
   logic                   pend_q, pend_d;
   logic                   tick_q, tick_d;
   logic                   wrap, start_acc, in_run, xfer;
   logic [CNT_WIDTH-1:0]   dm1;

   // D = max(div,1), so both 0 and 1 give a terminal count of 0.
   assign dm1       = (div_q == '0) ? '0 : div_q - CNT_WIDTH'(1);
   assign in_run    = (state_q == ST_RUN);
   assign start_acc = (state_q == ST_IDLE) && bus.start && !bus.stop;
   assign xfer      = bus.cfg_valid && !pend_q;
   assign tc_inc    = tc_q + BURST_WIDTH'(1);

   tick_period_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (start_acc),
      .en_i    (in_run),
      .dm1_i   (dm1),
      .wrap_o  (wrap)
   );

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      burst_d    = burst_q;
      sh_div_d   = sh_div_q;
      sh_burst_d = sh_burst_q;
      pend_d     = pend_q;
      tc_d       = tc_q;
      tick_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_acc) begin
               state_d = ST_RUN;
               tc_d    = '0;
            end
         end
         ST_RUN: begin
            if (bus.stop) begin
               // Abort wins over a coincident boundary: no tick, count held.
               state_d = ST_IDLE;
            end else if (wrap) begin
               tick_d = 1'b1;
               tc_d   = tc_inc;
               // >= so a shortened burst already passed ends on the next tick.
               if (burst_q != '0 && tc_inc >= burst_q) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Shadow is released at the boundary closing the current period, or at stop.
      if (pend_q && in_run && (wrap || bus.stop)) begin
         div_d   = sh_div_q;
         burst_d = sh_burst_q;
         pend_d  = 1'b0;
      end

      // A transfer coinciding with an accepted start goes to the shadow so the
      // run begins on the old config; likewise any transfer during a live run.
      if (xfer) begin
         if ((in_run && !bus.stop) || start_acc) begin
            sh_div_d   = bus.cfg_div;
            sh_burst_d = bus.cfg_burst;
            pend_d     = 1'b1;
         end else begin
            div_d   = bus.cfg_div;
            burst_d = bus.cfg_burst;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         div_q      <= CNT_WIDTH'(DEFAULT_DIV);
         burst_q    <= '0;
         sh_div_q   <= '0;
         sh_burst_q <= '0;
         pend_q     <= 1'b0;
         tc_q       <= '0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         burst_q    <= burst_d;
         sh_div_q   <= sh_div_d;
         sh_burst_q <= sh_burst_d;
         pend_q     <= pend_d;
         tc_q       <= tc_d;
         tick_q     <= tick_d;
      end
   end

   assign bus.tick       = tick_q;
   assign bus.busy       = (state_q == ST_RUN);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.tick_count = tc_q;
   assign bus.cfg_ready  = !pend_q;
endmodule

// File: tb/tb_tick_sequencer.sv
module tb_tick_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tick_sequencer_if #(.CNT_WIDTH(16), .BURST_WIDTH(16)) ifc ();

   tick_sequencer #(.CNT_WIDTH(16), .BURST_WIDTH(16), .DEFAULT_DIV(100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        cv;
      logic [15:0] div;
      logic [15:0] burst;
      logic        start;
      logic        stop;
      logic        tick;
      logic        busy;
      logic        done;
      logic        ready;
      logic [15:0] tc;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string name, input logic t, input logic b, input logic d,
                          input logic r, input logic [15:0] c);
      chk({name, ".tick"}, ifc.tick, t);
      chk({name, ".busy"}, ifc.busy, b);
      chk({name, ".done"}, ifc.done, d);
      chk({name, ".ready"}, ifc.cfg_ready, r);
      chk({name, ".tick_count"}, ifc.tick_count, c);
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cv, input logic [15:0] div, input logic [15:0] burst,
                        input logic st, input logic sp);
      ifc.cfg_valid = cv;
      ifc.cfg_div   = div;
      ifc.cfg_burst = burst;
      ifc.start     = st;
      ifc.stop      = sp;
   endtask

   task automatic push(input logic cv, input logic [15:0] div, input logic [15:0] burst,
                       input logic st, input logic sp, input logic t, input logic b,
                       input logic d, input logic r, input logic [15:0] c);
      vec_t v;
      v.cv = cv; v.div = div; v.burst = burst; v.start = st; v.stop = sp;
      v.tick = t; v.busy = b; v.done = d; v.ready = r; v.tc = c;
      tbl.push_back(v);
   endtask

   initial begin
      int nt;
      int nd;

      // Burst D=5, burst=3 (tick_count starts held at 10 from the continuous run).
      push(1, 5, 3, 0, 0,  0, 0, 0, 1, 10);
      push(0, 0, 0, 1, 0,  0, 1, 0, 1, 0);
      for (int i = 0; i < 4; i++) push(0, 0, 0, 0, 0,  0, 1, 0, 1, 0);
      push(0, 0, 0, 0, 0,  1, 1, 0, 1, 1);
      for (int i = 0; i < 4; i++) push(0, 0, 0, 0, 0,  0, 1, 0, 1, 1);
      push(0, 0, 0, 0, 0,  1, 1, 0, 1, 2);
      for (int i = 0; i < 4; i++) push(0, 0, 0, 0, 0,  0, 1, 0, 1, 2);
      push(0, 0, 0, 0, 0,  1, 0, 1, 1, 3);
      push(0, 0, 0, 0, 0,  0, 0, 0, 1, 3);
      // D=0, burst=2: two back-to-back ticks, last one alongside done.
      push(1, 0, 2, 0, 0,  0, 0, 0, 1, 3);
      push(0, 0, 0, 1, 0,  0, 1, 0, 1, 0);
      push(0, 0, 0, 0, 0,  1, 1, 0, 1, 1);
      push(0, 0, 0, 0, 0,  1, 0, 1, 1, 2);
      push(0, 0, 0, 0, 0,  0, 0, 0, 1, 2);
      // D=1, burst=2, with start ignored in RUN and in DONE, then start+stop in IDLE.
      push(1, 1, 2, 0, 0,  0, 0, 0, 1, 2);
      push(0, 0, 0, 1, 0,  0, 1, 0, 1, 0);
      push(0, 0, 0, 1, 0,  1, 1, 0, 1, 1);
      push(0, 0, 0, 0, 0,  1, 0, 1, 1, 2);
      push(0, 0, 0, 1, 0,  0, 0, 0, 1, 2);
      push(0, 0, 0, 1, 1,  0, 0, 0, 1, 2);

      // Reset state and idle behaviour.
      drive(0, 0, 0, 0, 0);
      repeat (3) edge1();
      chk_all("reset", 0, 0, 0, 1, 0);
      rst_n = 1'b1;
      nt = 0;
      repeat (1000) begin
         edge1();
         if (ifc.tick) nt++;
      end
      chk("idle_no_tick", nt, 0);
      chk_all("idle_after", 0, 0, 0, 1, 0);

      // Continuous, D=4.
      drive(1, 4, 0, 0, 0); edge1();
      drive(0, 0, 0, 1, 0); edge1();
      drive(0, 0, 0, 0, 0);
      chk_all("cont_start", 0, 1, 0, 1, 0);
      nd = 0;
      for (int i = 1; i <= 40; i++) begin
         edge1();
         chk("cont_tick", ifc.tick, (i % 4) == 0);
         if (ifc.done) nd++;
      end
      chk("cont_done_never", nd, 0);
      chk("cont_tc", ifc.tick_count, 10);
      drive(0, 0, 0, 0, 1); edge1();
      drive(0, 0, 0, 0, 0);
      chk_all("cont_stop", 0, 0, 0, 1, 10);

      // Table vectors.
      foreach (tbl[i]) begin
         drive(tbl[i].cv, tbl[i].div, tbl[i].burst, tbl[i].start, tbl[i].stop);
         edge1();
         chk_all($sformatf("vec%0d", i), tbl[i].tick, tbl[i].busy, tbl[i].done,
                 tbl[i].ready, tbl[i].tc);
      end
      drive(0, 0, 0, 0, 0);

      // Mid-run reconfiguration: D=8 running, D=3 offered 2 cycles after the first tick.
      drive(1, 8, 0, 0, 0); edge1();
      drive(0, 0, 0, 1, 0); edge1();
      drive(0, 0, 0, 0, 0);
      for (int i = 1; i <= 25; i++) begin
         if (i == 11) drive(1, 3, 0, 0, 0);
         edge1();
         drive(0, 0, 0, 0, 0);
         chk("recfg_tick", ifc.tick, (i == 8 || i == 16 || i == 19 || i == 22 || i == 25));
         chk("recfg_ready", ifc.cfg_ready, !(i >= 11 && i <= 15));
      end
      drive(0, 0, 0, 0, 1); edge1();
      drive(0, 0, 0, 0, 0);
      chk_all("recfg_stop", 0, 0, 0, 1, 5);

      // Stop landing on a boundary edge.
      drive(1, 4, 0, 0, 0); edge1();
      drive(0, 0, 0, 1, 0); edge1();
      drive(0, 0, 0, 0, 0);
      repeat (7) edge1();
      chk("stop_pre_tc", ifc.tick_count, 1);
      drive(0, 0, 0, 0, 1); edge1();
      drive(0, 0, 0, 0, 0);
      chk_all("stop_boundary", 0, 0, 0, 1, 1);

      // Asynchronous reset mid-burst with a pending shadow config.
      drive(1, 5, 3, 0, 0); edge1();
      drive(0, 0, 0, 1, 0); edge1();
      drive(0, 0, 0, 0, 0);
      repeat (7) edge1();
      drive(1, 9, 9, 0, 0); edge1();
      drive(0, 0, 0, 0, 0);
      chk("rst_pre_ready", ifc.cfg_ready, 0);
      chk("rst_pre_tc", ifc.tick_count, 1);
      #2 rst_n = 1'b0;
      #1 chk_all("rst_async", 0, 0, 0, 1, 0);
      edge1();
      rst_n = 1'b1;
      // Divider back at its default of 100, burst back to continuous.
      drive(0, 0, 0, 1, 0); edge1();
      drive(0, 0, 0, 0, 0);
      repeat (99) edge1();
      chk("rst_def_pre", ifc.tick, 0);
      edge1();
      chk_all("rst_def_tick", 1, 1, 0, 1, 1);
      drive(0, 0, 0, 0, 1); edge1();
      drive(0, 0, 0, 0, 0);
      // Fresh burst after reset: D=2, burst=1.
      drive(1, 2, 1, 0, 0); edge1();
      drive(0, 0, 0, 1, 0); edge1();
      drive(0, 0, 0, 0, 0);
      chk_all("post_rst_start", 0, 1, 0, 1, 0);
      edge1();
      chk_all("post_rst_k1", 0, 1, 0, 1, 0);
      edge1();
      chk_all("post_rst_k2", 1, 0, 1, 1, 1);
      edge1();
      chk_all("post_rst_k3", 0, 0, 0, 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
